// File: rtl/clk_ctrl.sv
// Clock-enable controller: programmable divider sequenced in HALT / RUN / STEP
// modes, producing a one-cycle core enable (ce) and a 50% display clock (cd).
// Divisor reloads are handshaked and only take effect at period boundaries.
module clk_ctrl #(
    parameter int unsigned    W       = 26,
    parameter logic [W-1:0]   DEF_DIV = W'(2500),
    parameter logic [15:0]    DB      = 16'd50000
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [1:0]   mode,
    input  logic [W-1:0] div_in,
    input  logic         div_ld,
    output logic         div_ack,
    output logic         div_err,
    input  logic         step_btn,
    output logic         ce,
    output logic         cd,
    output logic [1:0]   state
);

    typedef enum logic [1:0] {
        S_HALT = 2'b00,
        S_RUN  = 2'b01,
        S_STEP = 2'b10
    } state_t;

    state_t         r_state;
    state_t         w_state_nxt;

    logic [W-1:0]   r_ct;
    logic [W-1:0]   r_div;
    logic [W-1:0]   r_pend;
    logic           r_pv;
    logic           r_ce;
    logic           r_cd;
    logic           r_ack;
    logic           r_err;

    logic           r_sync1;
    logic           r_sync2;
    logic [15:0]    r_db_cnt;
    logic           r_db_lvl;
    logic           r_db_q;
    logic           r_armed;

    logic [W-1:0]   w_ct_nxt;
    logic           w_ce_nxt;
    logic           w_cd_nxt;
    logic           w_step_fire;
    logic           w_wrap;
    logic           w_apply;
    logic           w_ld_ok;
    logic           w_ld_bad;
    logic           w_db_rise;
    logic           w_db_fall;

    assign w_wrap    = (r_state == S_RUN) && (r_ct == (r_div - W'(1)));
    assign w_apply   = r_pv && ((r_state != S_RUN) || w_wrap);
    assign w_ld_ok   = div_ld && (div_in >= W'(2));
    assign w_ld_bad  = div_ld && (div_in <  W'(2));
    assign w_db_rise = r_db_lvl && !r_db_q;
    assign w_db_fall = !r_db_lvl && r_db_q;

    assign ce      = r_ce;
    assign cd      = r_cd;
    assign div_ack = r_ack;
    assign div_err = r_err;
    assign state   = r_state;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_HALT;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Mode decode plus next counter/enable/square-wave values; a state change zeroes everything
    always_comb begin
        w_state_nxt = S_HALT;
        w_ct_nxt    = '0;
        w_ce_nxt    = 1'b0;
        w_cd_nxt    = 1'b0;
        w_step_fire = 1'b0;
        case (mode)
            2'b01:   w_state_nxt = S_RUN;
            2'b10:   w_state_nxt = S_STEP;
            default: w_state_nxt = S_HALT;
        endcase
        if (w_state_nxt == r_state) begin
            case (r_state)
                S_RUN: begin
                    if (w_wrap) begin
                        w_ce_nxt = 1'b1;
                    end else begin
                        w_ct_nxt = r_ct + W'(1);
                    end
                    w_cd_nxt = (w_ct_nxt >= (r_div >> 1));
                end
                S_STEP: begin
                    w_step_fire = w_db_rise && r_armed;
                    w_ce_nxt    = w_step_fire;
                end
                default: begin
                    w_ce_nxt = 1'b0;
                end
            endcase
        end
    end

    // Divider datapath and divisor load handshake; apply uses the pre-edge pending value
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ct   <= '0;
            r_div  <= DEF_DIV;
            r_pend <= DEF_DIV;
            r_pv   <= 1'b0;
            r_ce   <= 1'b0;
            r_cd   <= 1'b0;
            r_ack  <= 1'b0;
            r_err  <= 1'b0;
        end else begin
            r_ct  <= w_ct_nxt;
            r_ce  <= w_ce_nxt;
            r_cd  <= w_cd_nxt;
            r_ack <= w_ld_ok;
            r_err <= w_ld_bad;
            if (w_apply) begin
                r_div <= r_pend;
                r_pv  <= 1'b0;
            end
            if (w_ld_ok) begin
                r_pend <= div_in;
                r_pv   <= 1'b1;
            end
        end
    end

    // Step button: 2-flop synchronizer, stability-window debouncer, edge detect and re-arm
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync1  <= 1'b0;
            r_sync2  <= 1'b0;
            r_db_cnt <= '0;
            r_db_lvl <= 1'b0;
            r_db_q   <= 1'b0;
            r_armed  <= 1'b1;
        end else begin
            r_sync1 <= step_btn;
            r_sync2 <= r_sync1;
            r_db_q  <= r_db_lvl;
            if (r_sync2 != r_db_lvl) begin
                if (r_db_cnt == (DB - 16'd1)) begin
                    r_db_lvl <= r_sync2;
                    r_db_cnt <= '0;
                end else begin
                    r_db_cnt <= r_db_cnt + 16'd1;
                end
            end else begin
                r_db_cnt <= '0;
            end
            if (w_db_fall) begin
                r_armed <= 1'b1;
            end else if (w_step_fire) begin
                r_armed <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_clk_ctrl.sv
// Self-checking bench for clk_ctrl: time-based reference model compared every
// cycle, plus directed scenarios with hand-computed period/latency expectations.
module tb_clk_ctrl;

    localparam int DEFV = 2500;
    localparam int DBV  = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [1:0]  mode = 2'b01;
    logic [25:0] div_in = '0;
    logic        div_ld = 1'b0;
    logic        step_btn = 1'b0;
    logic        div_ack, div_err, ce, cd;
    logic [1:0]  state;

    clk_ctrl #(.W(26), .DEF_DIV(26'd2500), .DB(16'd4)) dut (
        .clk(clk), .rst_n(rst_n), .mode(mode), .div_in(div_in), .div_ld(div_ld),
        .div_ack(div_ack), .div_err(div_err), .step_btn(step_btn),
        .ce(ce), .cd(cd), .state(state)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_err    = 0;
    int cyc_ctr  = 0;
    int ce_t[$];
    int hi_q[$];
    int hi_cnt   = 0;
    int ack_cnt  = 0;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc_ctr);
        end
    endtask

    always @(posedge clk) cyc_ctr <= cyc_ctr + 1;

    // Reference model: periods tracked as absolute start times, loads as a pending slot
    int m_st = 0, m_t0 = 0, m_div = DEFV, m_pend = DEFV, m_run = 0;
    bit m_pv = 0, m_lvl = 0, m_rise = 0, m_fall = 0, m_armed = 1, m_b1 = 0, m_b2 = 0;
    bit e_ce = 0, e_cd = 0, e_ack = 0, e_err = 0;
    int e_state = 0;

    always @(posedge clk or negedge rst_n) begin
        int cur, ns, age;
        bit wrap, apply;
        if (!rst_n) begin
            m_st = 0; m_div = DEFV; m_pend = DEFV; m_pv = 0;
            m_run = 0; m_lvl = 0; m_rise = 0; m_fall = 0; m_armed = 1; m_b1 = 0; m_b2 = 0;
            e_ce = 0; e_cd = 0; e_ack = 0; e_err = 0; e_state = 0;
        end else begin
            cur = cyc_ctr + 1;
            ns  = (mode == 2'b01) ? 1 : (mode == 2'b10) ? 2 : 0;
            age = cur - m_t0;
            wrap  = (m_st == 1) && (age == m_div);
            apply = m_pv && ((m_st != 1) || wrap);
            e_ce = 0; e_cd = 0;
            if (ns != m_st) begin
                m_t0 = cur;
            end else if (m_st == 1) begin
                if (wrap) begin
                    e_ce = 1; m_t0 = cur;
                end else begin
                    e_cd = (age >= m_div / 2);
                end
            end else begin
                m_t0 = cur;
                if (m_st == 2 && m_rise && m_armed) begin
                    e_ce = 1; m_armed = 0;
                end
            end
            if (m_fall) m_armed = 1;
            m_rise = 0; m_fall = 0;
            if (m_b2 != m_lvl) begin
                m_run++;
                if (m_run == DBV) begin
                    m_lvl = m_b2; m_run = 0;
                    if (m_lvl) m_rise = 1; else m_fall = 1;
                end
            end else begin
                m_run = 0;
            end
            m_b2 = m_b1; m_b1 = step_btn;
            e_ack = div_ld && (int'(div_in) >= 2);
            e_err = div_ld && (int'(div_in) < 2);
            if (apply) begin m_div = m_pend; m_pv = 0; end
            if (e_ack) begin m_pend = int'(div_in); m_pv = 1; end
            m_st = ns; e_state = ns;
        end
    end

    // Per-cycle compare against the model, plus ce/cd/ack bookkeeping for directed checks
    always @(negedge clk) begin
        check("ce",      int'(ce),      int'(e_ce));
        check("cd",      int'(cd),      int'(e_cd));
        check("div_ack", int'(div_ack), int'(e_ack));
        check("div_err", int'(div_err), int'(e_err));
        check("state",   int'(state),   e_state);
        if (ce) begin
            ce_t.push_back(cyc_ctr);
            hi_q.push_back(hi_cnt);
            hi_cnt = 0;
        end
        if (cd) hi_cnt++;
        if (div_ack) ack_cnt++;
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic clr();
        ce_t.delete();
        hi_q.delete();
        hi_cnt = 0;
    endtask

    function automatic int qat(input int idx);
        return (idx < ce_t.size()) ? ce_t[idx] : -1;
    endfunction

    function automatic int hat(input int idx);
        return (idx < hi_q.size()) ? hi_q[idx] : -1;
    endfunction

    initial begin
        int r, e, a0, p;
        // Reset release directly into RUN at the default divisor
        tick(3);
        check("reset_ce", int'(ce), 0);
        check("reset_state", int'(state), 0);
        rst_n = 1'b1;
        r = cyc_ctr;
        tick(2 * DEFV + 10);
        check("run_first_ce", qat(0), r + 1 + 2500);
        check("run_period", qat(1) - qat(0), 2500);
        check("run_cd_hi_first", hat(0), 1250);
        check("run_cd_hi", hat(1), 1250);

        // div=10, then reload 4 mid-period at ct=3
        mode = 2'b00; tick(1);
        div_ld = 1'b1; div_in = 26'd10; tick(1);
        check("ack_10", int'(div_ack), 1);
        div_ld = 1'b0; tick(2);
        clr();
        mode = 2'b01; e = cyc_ctr + 1;
        tick(4);
        div_ld = 1'b1; div_in = 26'd4; tick(1);
        check("ack_4", int'(div_ack), 1);
        div_ld = 1'b0; tick(20);
        check("p10_ce", qat(0), e + 10);
        check("p4_ce1", qat(1), e + 14);
        check("p4_ce2", qat(2), e + 18);
        check("p10_cd_hi", hat(0), 5);
        check("p4_cd_hi", hat(1), 2);

        // Rejected loads of 1 and 0
        a0 = ack_cnt;
        div_ld = 1'b1; div_in = 26'd1; tick(1);
        check("err_1", int'(div_err), 1);
        div_in = 26'd0; tick(1);
        check("err_0", int'(div_err), 1);
        div_ld = 1'b0; tick(12);
        check("err_no_ack", ack_cnt - a0, 0);
        check("err_div_kept", qat(ce_t.size() - 1) - qat(ce_t.size() - 2), 4);

        // Held load gives one ack per cycle; div=8 then HALT mid-period
        mode = 2'b00;
        a0 = ack_cnt;
        div_ld = 1'b1; div_in = 26'd8; tick(3);
        div_ld = 1'b0; tick(2);
        check("held_acks", ack_cnt - a0, 3);
        clr();
        mode = 2'b01; e = cyc_ctr + 1;
        tick(6);
        check("cd_before_halt", int'(cd), 1);
        mode = 2'b00; tick(1);
        check("halt_ce", int'(ce), 0);
        check("halt_cd", int'(cd), 0);
        check("halt_state", int'(state), 0);
        tick(3);
        clr();
        mode = 2'b01; e = cyc_ctr + 1;
        tick(10);
        check("rerun_first_ce", qat(0), e + 8);

        // Single-step with bounce, release/re-press, and held button
        mode = 2'b10; tick(3);
        clr();
        step_btn = 1'b1; tick(1);
        step_btn = 1'b0; tick(1);
        step_btn = 1'b1; tick(20);
        check("step_one", ce_t.size(), 1);
        step_btn = 1'b0; tick(10);
        step_btn = 1'b1; p = cyc_ctr;
        tick(12);
        check("step_two", ce_t.size(), 2);
        check("step_latency", qat(1), p + 7);
        tick(20);
        check("step_hold", ce_t.size(), 2);
        step_btn = 1'b0; tick(10);

        // Asynchronous reset with a load pending in RUN
        mode = 2'b01; tick(5);
        div_ld = 1'b1; div_in = 26'd50; tick(1);
        div_ld = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        check("arst_ack", int'(div_ack), 0);
        check("arst_ce", int'(ce), 0);
        check("arst_cd", int'(cd), 0);
        check("arst_state", int'(state), 0);
        tick(2);
        rst_n = 1'b1; r = cyc_ctr;
        a0 = ack_cnt;
        clr();
        tick(100);
        check("post_rst_ack", ack_cnt - a0, 0);
        check("post_rst_ce", ce_t.size(), 0);
        tick(2500);
        check("post_rst_div", qat(0), r + 1 + 2500);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule

// File: doc/clk_ctrl.md
# clk_ctrl

Clock-enable controller for the processor core. It owns a programmable divider and sequences it in three modes: free-running at the divided rate, single-step from a debounced push-button, or halted. It produces a one-cycle clock-enable pulse `ce` for the core and a 50% square wave `cd` for the display and LEDs. Divisor reloads use a request/acknowledge handshake and are applied only at period boundaries, so no period is ever truncated.

## Interface

Parameters:
- `W`: default 26. Divisor and counter width.
- `DEF_DIV`: default 26'd2500. Divisor after reset; must be ≥ 2.
- `DB`: default 16'd50000. Debounce stability window, in clock cycles.

Ports:
- `clk` input 1: single system clock, rising edge.
- `rst_n` input 1: reset, asynchronous, active-low.
- `mode` input 2: 00 HALT, 01 RUN, 10 STEP, 11 HALT.
- `div_in` input W: requested divisor.
- `div_ld` input 1: load request, sampled on every clock edge.
- `div_ack` output 1: one-cycle pulse; load accepted.
- `div_err` output 1: one-cycle pulse; load rejected because `div_in` < 2.
- `step_btn` input 1: raw, asynchronous step push-button.
- `ce` output 1: one-cycle clock-enable pulse to the core.
- `cd` output 1: divided square wave.
- `state` output 2: current FSM state (00 HALT, 01 RUN, 10 STEP).

## Operation

Reset values:
- `ce` = 0, `cd` = 0, `div_ack` = 0, `div_err` = 0, `state` = HALT.
- `ct` = 0, `div` = DEF_DIV, pending-valid `pv` = 0.
- Synchronizer flops = 0, debounce counter = 0, debounced level = 0, step armed = 1.

FSM states HALT, RUN, STEP:
- `mode` is decoded every edge. When the decoded state differs from the current state, the next state is taken immediately.
- On every state change: `ct` ← 0, `cd` ← 0, and no `ce` is issued on that edge.

RUN:
- `ct` counts 0 .. `div`−1.
- At `ct` == `div`−1: `ct` ← 0 and `ce` ← 1. On all other edges `ce` ← 0.
- `cd` ← 1 when the next `ct` ≥ `div`>>1, else 0. Period is `div` cycles; low time is floor(`div`/2) cycles.

HALT:
- `ct` held at 0, `ce` = 0, `cd` = 0.

STEP:
- `ct` held at 0, `cd` = 0.
- `step_btn` passes through a 2-flop synchronizer. The debounced level changes only after the synchronized input has differed from it for DB consecutive cycles; any bounce resets the debounce counter.
- On a debounced rising edge while armed: `ce` ← 1 for exactly one cycle, then armed ← 0.
- Armed is set back to 1 on a debounced falling edge.
- The debouncer keeps running in all states. A press completed while in RUN or HALT does not produce a step.

Divisor load:
- On an edge with `div_ld` = 1 and `div_in` ≥ 2: pending register ← `div_in`, `pv` ← 1, `div_ack` ← 1.
- On an edge with `div_ld` = 1 and `div_in` < 2: `div_err` ← 1; pending register and `pv` unchanged.
- A load while `pv` = 1 overwrites the pending value; the latest request wins.
- `div_ld` held high for N cycles produces N acks.
- Apply pending: `div` ← pending and `pv` ← 0 on an RUN wrap edge (`ct` == `div`−1), or on any edge where the state is HALT or STEP. Application lags acceptance by at least one edge.
- Simultaneous load and apply on the same edge: the register value from before the edge is applied, and the new request becomes pending.

## Timing

- Enter RUN at edge k (`ct` = 0): first `ce` is high after edge k+`div`, then every `div` cycles.
- `cd` first rises after edge k+floor(`div`/2).
- `div_ack` and `div_err` are high for the cycle following the sampling edge.
- Step latency from a clean press: 2 synchronizer cycles + DB cycles + 1 registered cycle until `ce`.
- Leaving RUN mid-period: `ce` and `cd` are 0 from the next cycle, and the partial period is discarded.
- `rst_n` low mid-operation: all registers take their reset values asynchronously, and any pending load is lost.
- All outputs are registered.

## Test plan

- Reset release with `mode`=01, DEF_DIV=2500: first `ce` 2500 cycles after RUN entry, then every 2500 cycles; `cd` low 1250 cycles, high 1250 cycles.
- In RUN with `div`=10, load `div_in`=4 at `ct`=3: `div_ack` next cycle; current period stays 10 cycles, following periods 4 cycles; `cd` pattern 2 low, 2 high.
- Load `div_in`=1 and then `div_in`=0: `div_err` pulses each time; `div` unchanged and `div_ack` never asserted.
- `mode`=10, DB=4, step_btn bounces 1-0-1 and then holds high 20 cycles: exactly one `ce` pulse. Release and press again: a second pulse. Hold without release: no further pulses.
- RUN with `div`=8, switch to HALT at `ct`=5: `ce` and `cd` are 0 next cycle. Return to RUN: first `ce` 8 cycles after re-entry.
- Assert `rst_n`=0 while `pv`=1 in RUN: outputs are 0 immediately. After release, `div`=DEF_DIV and no `div_ack` or `ce` until re-stimulated.
